// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet arbiter: FSM state encoding,
// width helpers and the round-robin pick used to choose the next requester.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } arb_state_t;

  // Upper bound on requesters supported by rr_pick.
  localparam int MAX_REQ = 32;
  localparam int PICK_W  = 5;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // First requester with valid set, searching from ptr+1 upwards with wrap at n.
  // Walking k downwards lets the smallest distance win by being assigned last.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    logic [PICK_W-1:0] idx;
    rr_pick = ptr;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = PICK_W'((ptr + k) % n);
        if (valid[idx]) rr_pick = 32'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/axis_id_fifo.sv
// In-order FIFO of requester IDs for packets currently inside the processor.
// Full/empty come from the registered count, so a pop frees a slot one cycle later.
module axis_id_fifo
  import axis_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-granular arbiter sharing one stream processor between
// N_REQ requesters; responses are routed back in order using an ID FIFO.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic [N_REQ-1:0]                s_tvalid,
  output logic [N_REQ-1:0]                s_tready,
  input  logic [N_REQ*DATA_WIDTH-1:0]     s_tdata,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [N_REQ-1:0]                s_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_tkeep,
  output logic                            m_tlast,
  input  logic                            p_tvalid,
  output logic                            p_tready,
  input  logic [DATA_WIDTH-1:0]           p_tdata,
  input  logic [DATA_WIDTH/8-1:0]         p_tkeep,
  input  logic                            p_tlast,
  output logic [N_REQ-1:0]                r_tvalid,
  input  logic [N_REQ-1:0]                r_tready,
  output logic [N_REQ*DATA_WIDTH-1:0]     r_tdata,
  output logic [N_REQ*DATA_WIDTH/8-1:0]   r_tkeep,
  output logic [N_REQ-1:0]                r_tlast,
  output logic                            busy,
  output logic [id_width(N_REQ)-1:0]      grant_id,
  output arb_state_t                      state
);

  // All streams use AXI-Stream valid/ready: a beat moves on a cycle where both
  // valid and ready are high; valid never waits on ready, ready may wait on valid.

  localparam int IDW = id_width(N_REQ);
  localparam int KW  = DATA_WIDTH / 8;

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IDW-1:0] fifo_head;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Grant happens in IDLE without moving data; the granted lane is then
  // connected straight through to the processor until its tlast beat.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    fifo_push = 1'b0;
    s_tready  = '0;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|s_tvalid) && !fifo_full) begin
          grant_d   = IDW'(rr_pick(MAX_REQ'(s_tvalid), 32'(rr_ptr_q), N_REQ));
          fifo_push = 1'b1;
          state_d   = FWD;
        end
      end
      FWD: begin
        m_tvalid          = s_tvalid[grant_q];
        m_tdata           = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep           = s_tkeep[grant_q*KW +: KW];
        m_tlast           = s_tlast[grant_q];
        s_tready[grant_q] = m_tready;
        if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  axis_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .arstn     (arstn),
    .push      (fifo_push),
    .push_data (grant_d),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Return path only steers valid/last/ready; data and keep go to every lane.
  always_comb begin
    r_tvalid = '0;
    r_tlast  = '0;
    p_tready = 1'b0;
    if (!fifo_empty) begin
      r_tvalid[fifo_head] = p_tvalid;
      r_tlast[fifo_head]  = p_tlast;
      p_tready            = r_tready[fifo_head];
    end
  end

  assign fifo_pop = p_tvalid & p_tready & p_tlast;
  assign r_tdata  = {N_REQ{p_tdata}};
  assign r_tkeep  = {N_REQ{p_tkeep}};

  assign busy     = (state_q == FWD) || !fifo_empty;
  assign grant_id = grant_q;
  assign state    = state_q;

endmodule
